// File: rtl/sdrd_picture_sched_if.sv
// sdrd_picture_sched_if
//   Bundles every signal between the picture-entry sequencer and its
//   neighbours: the directory scanner (ENT_IN*, SCAN_DONE), the image
//   loader (NEXT_REQ, RESTART, ENT_OUT*), the recirculating entry buffer
//   (BUF_*) and the status outputs (ENT_COUNT, CUR_INDEX, PLAY_RDY,
//   NO_PICT, ERR).
//   master : the sequencer itself
//   slave  : the environment (scanner, loader, buffer)
interface sdrd_picture_sched_if #(
  parameter int CNT_W = 8
);
  logic [31:0]      ENT_IN;
  logic             ENT_IN_VALID;
  logic             ENT_IN_READY;
  logic             SCAN_DONE;
  logic             NEXT_REQ;
  logic             RESTART;
  logic [31:0]      ENT_OUT;
  logic             ENT_OUT_VALID;
  logic             ENT_OUT_ACK;
  logic             BUF_WR;
  logic             BUF_RD;
  logic [31:0]      BUF_DIN;
  logic [31:0]      BUF_DOUT;
  logic             BUF_VALID;
  logic             BUF_EMPTY;
  logic             BUF_FULL;
  logic [CNT_W-1:0] ENT_COUNT;
  logic [CNT_W-1:0] CUR_INDEX;
  logic             PLAY_RDY;
  logic             NO_PICT;
  logic             ERR;

  modport master (
    input  ENT_IN, ENT_IN_VALID, SCAN_DONE, NEXT_REQ, RESTART, ENT_OUT_ACK,
           BUF_DOUT, BUF_VALID, BUF_EMPTY, BUF_FULL,
    output ENT_IN_READY, ENT_OUT, ENT_OUT_VALID, BUF_WR, BUF_RD, BUF_DIN,
           ENT_COUNT, CUR_INDEX, PLAY_RDY, NO_PICT, ERR
  );

  modport slave (
    output ENT_IN, ENT_IN_VALID, SCAN_DONE, NEXT_REQ, RESTART, ENT_OUT_ACK,
           BUF_DOUT, BUF_VALID, BUF_EMPTY, BUF_FULL,
    input  ENT_IN_READY, ENT_OUT, ENT_OUT_VALID, BUF_WR, BUF_RD, BUF_DIN,
           ENT_COUNT, CUR_INDEX, PLAY_RDY, NO_PICT, ERR
  );
endinterface

// File: rtl/sdrd_picture_sched.sv
// sdrd_picture_sched
//   Sequencer for the recirculating picture-entry buffer in the SD-read
//   path. Loads entries from the directory scanner, then hands one entry
//   per NEXT_REQ to the image loader. Every buffer read is rewritten at the
//   buffer tail, so the buffer behaves as a ring; RESTART rewinds the ring
//   to entry 0 by reading (and discarding) the remaining entries.
// Ports
//   CLK   : clock
//   RSTS  : synchronous active-high reset (shared with the buffer)
//   bus   : sdrd_picture_sched_if.master, scanner / loader / buffer / status
module sdrd_picture_sched #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 8,
  parameter int TMO   = 4
) (
  input logic                  CLK,
  input logic                  RSTS,
  sdrd_picture_sched_if.master bus
);
  localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO);

  typedef enum logic [3:0] {
    S_LOAD,
    S_PLAY_IDLE,
    S_FETCH,
    S_WAIT_V,
    S_PRESENT,
    S_REWIND_RD,
    S_REWIND_WAIT,
    S_NONE,
    S_ERROR
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] index_reg;
  logic [CNT_W-1:0] discard_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [31:0]      ent_out_reg;

  logic             load_accept;
  logic             rd_issue;
  logic             tmo_expired;
  logic [CNT_W-1:0] count_after;

  // Writes happen only in LOAD and reads never do, so a loader write can
  // never land on top of the buffer's own tail rewrite.
  assign bus.ENT_IN_READY = !RSTS && (state_reg == S_LOAD) && !bus.BUF_FULL &&
                            (count_reg < CNT_W'(DEPTH));
  assign load_accept      = bus.ENT_IN_READY && bus.ENT_IN_VALID;
  assign count_after      = count_reg + {{(CNT_W-1){1'b0}}, load_accept};

  // A read is only issued with the buffer non-empty; with a single entry the
  // buffer is empty until the rewrite of the previous read lands.
  assign rd_issue    = !RSTS && !bus.BUF_EMPTY &&
                       ((state_reg == S_FETCH) || (state_reg == S_REWIND_RD));
  // tmo_reg counts the wait cycles after BUF_RD, the last allowed one is TMO.
  assign tmo_expired = (tmo_reg == TMO_W'(TMO - 1));

  assign bus.BUF_WR        = load_accept;
  assign bus.BUF_DIN       = bus.ENT_IN;
  assign bus.BUF_RD        = rd_issue;
  assign bus.ENT_OUT       = ent_out_reg;
  assign bus.ENT_OUT_VALID = (state_reg == S_PRESENT);
  assign bus.ENT_COUNT     = count_reg;
  assign bus.CUR_INDEX     = index_reg;
  assign bus.PLAY_RDY      = (state_reg == S_PLAY_IDLE);
  assign bus.NO_PICT       = (state_reg == S_NONE);
  assign bus.ERR           = (state_reg == S_ERROR);

  always_ff @(posedge CLK) begin
    if (RSTS) begin
      state_reg   <= S_LOAD;
      count_reg   <= '0;
      index_reg   <= '0;
      discard_reg <= '0;
      tmo_reg     <= '0;
      ent_out_reg <= '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          count_reg <= count_after;
          // An entry accepted together with SCAN_DONE still counts.
          if (bus.SCAN_DONE) begin
            state_reg <= (count_after == '0) ? S_NONE : S_PLAY_IDLE;
          end
        end
        S_PLAY_IDLE: begin
          // RESTART wins over NEXT_REQ even when the rewind is a no-op.
          if (bus.RESTART) begin
            if (index_reg != '0) begin
              discard_reg <= count_reg - index_reg;
              state_reg   <= S_REWIND_RD;
            end
          end else if (bus.NEXT_REQ) begin
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_issue) begin
            tmo_reg   <= '0;
            state_reg <= S_WAIT_V;
          end
        end
        S_WAIT_V: begin
          if (bus.BUF_VALID) begin
            ent_out_reg <= bus.BUF_DOUT;
            state_reg   <= S_PRESENT;
          end else if (tmo_expired) begin
            state_reg <= S_ERROR;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        S_PRESENT: begin
          if (bus.ENT_OUT_ACK) begin
            index_reg <= (index_reg == count_reg - CNT_W'(1)) ? '0
                                                             : index_reg + CNT_W'(1);
            state_reg <= S_PLAY_IDLE;
          end
        end
        S_REWIND_RD: begin
          if (rd_issue) begin
            tmo_reg   <= '0;
            state_reg <= S_REWIND_WAIT;
          end
        end
        S_REWIND_WAIT: begin
          // Data is thrown away; once the last remaining entry has cycled
          // through, the ring head is back at entry 0.
          if (bus.BUF_VALID) begin
            if (discard_reg == CNT_W'(1)) begin
              index_reg <= '0;
              state_reg <= S_PLAY_IDLE;
            end else begin
              discard_reg <= discard_reg - CNT_W'(1);
              state_reg   <= S_REWIND_RD;
            end
          end else if (tmo_expired) begin
            state_reg <= S_ERROR;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        S_NONE, S_ERROR: begin
          state_reg <= state_reg;
        end
        default: begin
          state_reg <= S_ERROR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdrd_picture_sched.sv
// tb_sdrd_picture_sched
//   Self-checking bench for sdrd_picture_sched. A behavioural ring buffer
//   answers BUF_RD one cycle later and re-appends every read entry at its
//   tail. A reference model (list of loaded entries plus a ring index)
//   pushes the expected entry into a scoreboard for each accepted
//   NEXT_REQ; a separate monitor pops and compares whenever ENT_OUT_VALID
//   rises, and also acknowledges with a random delay.
`timescale 1ns/1ps
module tb_sdrd_picture_sched;
  localparam int DEPTH = 128;
  localparam int CNT_W = 8;
  localparam int TMO   = 4;

  logic CLK  = 1'b0;
  logic RSTS = 1'b1;
  always #5 CLK = ~CLK;

  sdrd_picture_sched_if #(.CNT_W(CNT_W)) bus();

  sdrd_picture_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .CLK  (CLK),
    .RSTS (RSTS),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural ring buffer ----------------
  logic [31:0] buf_q[$];
  bit          stall_rd = 1'b0;
  int          rw_delay = 0;
  logic        pend_valid;
  int          pend_left;
  logic [31:0] pend_data;

  always @(posedge CLK) begin
    if (RSTS) begin
      buf_q.delete();
      pend_valid    <= 1'b0;
      pend_left     <= 0;
      pend_data     <= '0;
      bus.BUF_VALID <= 1'b0;
      bus.BUF_DOUT  <= '0;
      bus.BUF_EMPTY <= 1'b1;
      bus.BUF_FULL  <= 1'b0;
    end else begin
      bus.BUF_VALID <= 1'b0;
      if (pend_valid) begin
        if (pend_left == 0) begin
          buf_q.push_back(pend_data);
          pend_valid <= 1'b0;
        end else begin
          pend_left <= pend_left - 1;
        end
      end
      if (bus.BUF_WR) buf_q.push_back(bus.BUF_DIN);
      if (bus.BUF_RD && !stall_rd && buf_q.size() > 0) begin
        bus.BUF_VALID <= 1'b1;
        bus.BUF_DOUT  <= buf_q[0];
        pend_data     <= buf_q[0];
        pend_valid    <= 1'b1;
        pend_left     <= rw_delay;
        void'(buf_q.pop_front());
      end
      bus.BUF_EMPTY <= (buf_q.size() == 0);
      bus.BUF_FULL  <= (buf_q.size() >= DEPTH);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          req_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_list[$];
  int          ref_idx  = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          last_rd_cyc = -10;
  bit          loading  = 1'b1;
  bit          presented = 1'b0;
  int          ack_wait = 0;
  int          n_xact   = 0;
  exp_t        mon_e;

  // Monitor: protocol checks every cycle, scoreboard pop on each new ENT_OUT.
  initial begin
    bus.ENT_OUT_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RSTS) begin
        if (bus.BUF_WR) begin
          wr_count++;
          check("buf_wr_only_in_load", loading, 1'b1);
        end
        if (bus.BUF_RD) begin
          rd_count++;
          check("buf_rd_while_empty", bus.BUF_EMPTY, 1'b0);
          check("buf_rd_spacing_ge2", (cyc - last_rd_cyc) >= 2, 1'b1);
          last_rd_cyc = cyc;
        end
        if (bus.ERR)
          check("err_strobes_low", {bus.BUF_RD, bus.BUF_WR, bus.ENT_OUT_VALID, bus.ENT_IN_READY}, 4'b0);
        if (bus.ENT_OUT_VALID) begin
          if (!presented) begin
            presented = 1'b1;
            n_xact++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_ent_out: got 0x%08h, required no output", bus.ENT_OUT);
            end else begin
              mon_e = exp_q.pop_front();
              $display("xact %0d: ENT_OUT=0x%08h expected=0x%08h latency=%0d idx=%0d",
                       n_xact, bus.ENT_OUT, mon_e.data, cyc - mon_e.req_cyc, bus.CUR_INDEX);
              check("ent_out_data", bus.ENT_OUT, mon_e.data);
              if (mon_e.chk_lat) check("next_req_to_valid_latency", cyc - mon_e.req_cyc, 3);
            end
            ack_wait = $urandom_range(0, 2);
          end
          if (ack_wait == 0) bus.ENT_OUT_ACK = 1'b1;
          else ack_wait--;
        end else begin
          presented       = 1'b0;
          bus.ENT_OUT_ACK = 1'b0;
        end
      end else begin
        presented       = 1'b0;
        bus.ENT_OUT_ACK = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit chk_drain);
    if (chk_drain) check("scoreboard_drained", exp_q.size(), 0);
    RSTS = 1'b1;
    bus.ENT_IN = '0; bus.ENT_IN_VALID = 1'b0; bus.SCAN_DONE = 1'b0;
    bus.NEXT_REQ = 1'b0; bus.RESTART = 1'b0;
    stall_rd = 1'b0; rw_delay = 0;
    tick();
    check("rst_ent_in_ready", bus.ENT_IN_READY, 1'b0);
    check("rst_flags", {bus.ENT_OUT_VALID, bus.PLAY_RDY, bus.NO_PICT, bus.ERR, bus.BUF_RD, bus.BUF_WR}, 6'b0);
    check("rst_ent_out", bus.ENT_OUT, 32'h0);
    check("rst_count_index", {bus.ENT_COUNT, bus.CUR_INDEX}, 16'h0);
    RSTS = 1'b0;
    exp_q.delete(); ref_list.delete(); ref_idx = 0; loading = 1'b1;
    tick();
    check("load_ready_after_rst", bus.ENT_IN_READY, 1'b1);
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!bus.PLAY_RDY && n < 60) begin
      tick();
      n++;
    end
    check({name, "_play_rdy"}, bus.PLAY_RDY, 1'b1);
  endtask

  task automatic load(input logic [31:0] d, input bit done);
    bus.ENT_IN = d; bus.ENT_IN_VALID = 1'b1; bus.SCAN_DONE = done;
    if (ref_list.size() < DEPTH) ref_list.push_back(d);
    tick();
    bus.ENT_IN_VALID = 1'b0; bus.SCAN_DONE = 1'b0;
    if (done) loading = 1'b0;
  endtask

  task automatic scan_done();
    bus.SCAN_DONE = 1'b1;
    tick();
    bus.SCAN_DONE = 1'b0;
    loading = 1'b0;
  endtask

  // One NEXT_REQ round; optional second pulse lands in FETCH and must be dropped.
  task automatic do_next(input bit spurious);
    exp_t e;
    e.data    = ref_list[ref_idx];
    e.req_cyc = cyc;
    e.chk_lat = (rw_delay == 0);
    exp_q.push_back(e);
    ref_idx = (ref_idx + 1) % ref_list.size();
    bus.NEXT_REQ = 1'b1;
    tick();
    bus.NEXT_REQ = spurious;
    tick();
    bus.NEXT_REQ = 1'b0;
    wait_rdy("next");
  endtask

  task automatic do_restart(input bit with_next);
    int rd0  = rd_count;
    int expd = (ref_idx == 0) ? 0 : ref_list.size() - ref_idx;
    bus.RESTART  = 1'b1;
    bus.NEXT_REQ = with_next;
    tick();
    bus.RESTART  = 1'b0;
    bus.NEXT_REQ = 1'b0;
    wait_rdy("restart");
    check("rewind_discard_reads", rd_count - rd0, expd);
    ref_idx = 0;
    check("rewind_cur_index", bus.CUR_INDEX, ref_idx);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, rd0, w0, c0;
    do_reset(1'b0);

    // Three entries, four rounds, then rewinds.
    load(32'hA0, 1'b0); load(32'hA1, 1'b0); load(32'hA2, 1'b0);
    scan_done();
    check("a_ent_count", bus.ENT_COUNT, 3);
    check("a_play_rdy", bus.PLAY_RDY, 1'b1);
    for (int i = 0; i < 4; i++) do_next(i == 1);
    check("a_cur_index", bus.CUR_INDEX, ref_idx);
    do_restart(1'b0);
    do_next(1'b0);
    do_restart(1'b1);
    repeat (4) tick();
    check("a_restart_next_no_output", exp_q.size(), 0);

    // Randomized ring of random length with random requests and rewinds.
    do_reset(1'b1);
    n = $urandom_range(2, 12);
    for (int i = 0; i < n; i++) load($urandom, i == n - 1);
    check("rnd_ent_count", bus.ENT_COUNT, n);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        do_next($urandom_range(0, 3) == 0);
        check("rnd_cur_index", bus.CUR_INDEX, ref_idx);
      end else begin
        do_restart($urandom_range(0, 1) == 1);
      end
    end

    // Single entry loaded together with SCAN_DONE; slow rewrite forces FETCH to wait.
    do_reset(1'b1);
    load(32'h55, 1'b1);
    check("one_ent_count", bus.ENT_COUNT, 1);
    check("one_play_rdy", bus.PLAY_RDY, 1'b1);
    rw_delay = 4;
    for (int i = 0; i < 5; i++) do_next(1'b0);
    rw_delay = 0;
    repeat (8) tick();

    // Scan finished with no entries.
    do_reset(1'b1);
    scan_done();
    check("none_no_pict", bus.NO_PICT, 1'b1);
    rd0 = rd_count;
    bus.NEXT_REQ = 1'b1; tick(); bus.NEXT_REQ = 1'b0;
    repeat (4) tick();
    check("none_no_reads", rd_count - rd0, 0);
    check("none_state_held", {bus.NO_PICT, bus.PLAY_RDY, bus.ENT_OUT_VALID}, 3'b100);

    // Offer DEPTH+2 entries back to back.
    do_reset(1'b1);
    w0 = wr_count;
    for (int i = 0; i < DEPTH + 2; i++) load($urandom, 1'b0);
    check("full_accepted", wr_count - w0, DEPTH);
    check("full_ready_low", bus.ENT_IN_READY, 1'b0);
    check("full_ent_count", bus.ENT_COUNT, DEPTH);
    scan_done();
    do_next(1'b0);

    // Read timeout: buffer never answers.
    stall_rd = 1'b1;
    c0 = cyc;
    bus.NEXT_REQ = 1'b1; tick(); bus.NEXT_REQ = 1'b0;
    while (cyc < c0 + 1 + TMO) tick();
    check("tmo_rd_cycle", last_rd_cyc, c0 + 1);
    check("tmo_err_not_early", bus.ERR, 1'b0);
    tick();
    check("tmo_err_set", bus.ERR, 1'b1);
    bus.NEXT_REQ = 1'b1; bus.RESTART = 1'b1; tick();
    bus.NEXT_REQ = 1'b0; bus.RESTART = 1'b0;
    repeat (3) tick();
    check("tmo_err_sticky", bus.ERR, 1'b1);
    do_reset(1'b1);
    check("post_err_count", bus.ENT_COUNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sdrd_picture_sched.md
# sdrd_picture_sched

Sequencer for the recirculating picture-entry buffer in the SD-read path. It loads 32-bit picture entries from the directory scanner into the buffer, then serves one entry per request to the image loader. Every buffer read rewrites the entry at the tail, so the buffer acts as a ring. The block tracks entry count and current index, and can rewind the ring to entry 0. It also guarantees that loader writes never collide with the buffer's internal rewrite.

## Interface
- DEPTH, 128, buffer capacity in entries
- CNT_W, 8, width of count/index (≥ clog2(DEPTH+1))
- TMO, 4, cycles allowed from BUF_RD to BUF_VALID
- CLK  in  1  clock; single clock domain
- RSTS  in  1  synchronous active-high reset; the buffer shares it
- ENT_IN  in  32  entry from the directory scanner
- ENT_IN_VALID  in  1  ENT_IN valid
- ENT_IN_READY  out  1  block accepts ENT_IN this cycle
- SCAN_DONE  in  1  one-cycle pulse, scan finished
- NEXT_REQ  in  1  one-cycle pulse, loader wants the next entry
- RESTART  in  1  one-cycle pulse, rewind to entry 0
- ENT_OUT  out  32  entry presented to the loader
- ENT_OUT_VALID  out  1  ENT_OUT valid; held until ACK
- ENT_OUT_ACK  in  1  loader consumed ENT_OUT
- BUF_WR, BUF_RD  out  1  buffer write/read strobes
- BUF_DIN  out  32  buffer write data
- BUF_DOUT  in  32  buffer read data
- BUF_VALID, BUF_EMPTY, BUF_FULL  in  1  buffer status
- ENT_COUNT  out  CNT_W  entries loaded
- CUR_INDEX  out  CNT_W  index of the next entry to be presented
- PLAY_RDY  out  1  high in PLAY_IDLE
- NO_PICT  out  1  scan finished with zero entries (sticky)
- ERR  out  1  read timeout (sticky)

## Operation
- States: LOAD, PLAY_IDLE, FETCH, WAIT_V, PRESENT, REWIND_RD, REWIND_WAIT, NONE, ERROR.
- LOAD:
  - ENT_IN_READY = !BUF_FULL && ENT_COUNT < DEPTH.
  - On ENT_IN_VALID && ENT_IN_READY: BUF_WR=1, BUF_DIN=ENT_IN, ENT_COUNT+1.
  - SCAN_DONE: if the count after this cycle's accept is 0 → NONE, else → PLAY_IDLE.
  - An entry accepted in the same cycle as SCAN_DONE is counted.
- BUF_WR is asserted only in LOAD. BUF_RD is never asserted in LOAD. This prevents collision with the buffer's rewrite.
- PLAY_IDLE:
  - RESTART has priority over NEXT_REQ.
  - RESTART with CUR_INDEX=0 is a no-op. Otherwise load the discard counter with ENT_COUNT−CUR_INDEX and go to REWIND_RD.
  - NEXT_REQ → FETCH.
  - Pulses arriving in any other state are dropped; there is no queueing.
- FETCH: if BUF_EMPTY=0, assert BUF_RD for one cycle and go to WAIT_V. Otherwise wait in FETCH; the rewrite is still in flight.
- WAIT_V:
  - On BUF_VALID, capture BUF_DOUT into ENT_OUT and go to PRESENT.
  - If TMO cycles elapse after BUF_RD without BUF_VALID → ERROR.
- PRESENT:
  - ENT_OUT_VALID=1, ENT_OUT stable.
  - On ACK: CUR_INDEX = (CUR_INDEX==ENT_COUNT−1) ? 0 : CUR_INDEX+1, then → PLAY_IDLE.
- REWIND_RD / REWIND_WAIT:
  - Same read rule as FETCH/WAIT_V, same timeout; data is discarded.
  - Each BUF_VALID decrements the discard counter.
  - At 0: CUR_INDEX=0, → PLAY_IDLE.
- NONE: NO_PICT=1. Only reset exits this state.
- ERROR: ERR=1, all strobes 0. Only reset exits this state.

## Timing
- Reset values:
  - State LOAD.
  - All strobes and valids 0; ENT_IN_READY 0 during the reset cycle.
  - ENT_OUT=0, ENT_COUNT=0, CUR_INDEX=0, PLAY_RDY=0, NO_PICT=0, ERR=0.
- RSTS asserted mid-operation: the next cycle is the reset state.
- The buffer is cleared by the same RSTS, so the ring and the count stay consistent.
- Buffer assumption: read latency 1; BUF_VALID and BUF_DOUT arrive the cycle after BUF_RD.
- Read spacing:
  - Consecutive BUF_RD pulses are ≥2 cycles apart.
  - The next read waits for the previous BUF_VALID and for BUF_EMPTY=0.
  - This spacing covers ENT_COUNT=1, where the buffer is empty until the rewrite lands.
- NEXT_REQ to ENT_OUT_VALID: 3 cycles with a non-empty buffer.
  - t: NEXT_REQ sampled → FETCH
  - t+1: BUF_RD
  - t+2: BUF_VALID, capture
  - t+3: ENT_OUT_VALID
- ENT_OUT_ACK sampled in the same cycle ENT_OUT_VALID rises is accepted. PLAY_RDY rises the next cycle.

## Test plan
- Load 0xA0,0xA1,0xA2; SCAN_DONE; four NEXT_REQ/ACK rounds → ENT_OUT A0,A1,A2,A0; CUR_INDEX ends at 1; BUF_WR never asserted after LOAD.
- After the above, RESTART → 2 discard reads (3−1); CUR_INDEX=0; next NEXT_REQ yields A0. Same-cycle RESTART+NEXT_REQ → rewind only.
- ENT_COUNT=1 (entry 0x55): five back-to-back NEXT_REQ rounds → 0x55 each time; no BUF_RD while BUF_EMPTY=1.
- SCAN_DONE with no entries → NO_PICT=1 next cycle; NEXT_REQ has no effect. Entry plus SCAN_DONE in the same cycle → ENT_COUNT=1, PLAY_RDY.
- Offer DEPTH+2 entries → exactly DEPTH accepted; ENT_IN_READY low afterwards; ENT_COUNT=128.
- Hold BUF_VALID low after BUF_RD → ERR=1 at cycle TMO; strobes stay 0; RSTS clears ERR, and state returns to LOAD.
